image_read_arbiter: RTL and testbench
=====================================

IMAGE_READ_ARBITER -- requirements
Module: image_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: image buffer address width.
REQ-002 Parameter DATA_W, default 12: pixel width.
REQ-003 Parameter RD_LAT, default 1, legal range 1-4: buffer read latency in cycles.
REQ-004 Parameter TIMEOUT, default 255, legal range 1-255: count of idle owner cycles before forced release.
REQ-005 Port clock  in  1: single clock; all state changes on its rising edge.
REQ-006 Port reset_bar  in  1: asynchronous, active-low reset.
REQ-007 Ports req0, req1  in  1: requester n wants a read beat this cycle.
REQ-008 Ports addr0, addr1  in  ADDR_W: read address of requester n.
REQ-009 Ports last0, last1  in  1: the current beat is the final beat of the burst.
REQ-010 Ports gnt0, gnt1  out  1: the beat of requester n is accepted this cycle.
REQ-011 Ports rvalid0, rvalid1  out  1: rdata carries the data for requester n.
REQ-012 Ports rdata0, rdata1  out  DATA_W: return data, both driven from mem_rdata.
REQ-013 Port mem_re  out  1: read enable to the image buffer.
REQ-014 Port mem_addr  out  ADDR_W: read address to the image buffer.
REQ-015 Port mem_rdata  in  DATA_W: buffer read data, valid RD_LAT cycles after mem_re.
REQ-016 Port busy  out  1: the arbiter is not in IDLE, or a read is still in flight.

Function
REQ-017 The arbiter SHALL use states IDLE, OWN0 and OWN1, plus a 1-bit round-robin pointer `prio` that names the favoured requester.
REQ-018 In IDLE with a single reqn high, the next state SHALL be OWNn; with both high, the next state SHALL be OWN<prio>; no request is granted while in IDLE.
REQ-019 In OWNn, gntn = mem_re = reqn combinationally, mem_addr = addrn, and the other gnt SHALL be 0.
REQ-020 When mem_re is low, mem_addr SHALL hold addr0 and gnt0 and gnt1 SHALL both be 0.
REQ-021 A granted beat with lastn=1 SHALL end the burst; the next state SHALL be OWN<other> if the other req is high (no bubble), else IDLE; prio SHALL become the other requester.
REQ-022 When reqn is low in OWNn, ownership SHALL be retained and an idle counter SHALL increment; any granted beat SHALL clear the counter.
REQ-023 When the idle counter reaches TIMEOUT, ownership SHALL be released exactly as a last beat would be (REQ-021), and the counter SHALL clear.
REQ-024 Every granted beat SHALL enter an RD_LAT-deep shift register of {valid, owner tag}; rvalidn SHALL assert exactly RD_LAT cycles after gntn, for one cycle per beat.
REQ-025 The tag pipeline SHALL route correctly across back-to-back owner switches, so that beats of OWN0 and then OWN1 return in issue order with the correct rvalid.
REQ-026 At most one rvalid SHALL be high in any cycle.
REQ-027 busy SHALL be high whenever state != IDLE or any pipeline valid bit is set.
REQ-028 A burst of one beat (req and last high together) SHALL be legal and SHALL be followed by the release rule of REQ-021.
REQ-029 Address values SHALL pass through unmodified; the arbiter SHALL perform no address arithmetic and no wrap-around handling.

Reset
REQ-030 While reset_bar=0: state=IDLE, prio=0, idle counter=0, pipeline valid bits cleared.
REQ-031 While reset_bar=0, all outputs SHALL be 0, with mem_addr and rdata as don't-care-free zeros apart from rdata following mem_rdata.
REQ-032 An assertion of reset mid-burst SHALL drop all in-flight reads; no rvalid SHALL follow the release of reset.
REQ-033 Reset release SHALL be used only after synchronisation by the top level; the first grant is possible 2 cycles after release.

Verification
REQ-034 req0 burst at addresses 0x0010-0x0013 with last0 on the 4th beat and RD_LAT=1 -> mem_re high for 4 cycles starting 1 cycle after req0; rvalid0 high for 4 cycles, offset 1 cycle; then IDLE.
REQ-035 req0 and req1 rise together after reset -> OWN0 first; on last0, OWN1 follows with no gap; a second simultaneous request after that -> OWN0 (prio toggled).
REQ-036 RD_LAT=3, a 2-beat burst by requester 0 immediately followed by a 2-beat burst by requester 1 -> rvalid0, rvalid0, rvalid1, rvalid1 in consecutive cycles starting 3 cycles after the first gnt0.
REQ-037 TIMEOUT=4, owner 1 drops req1 without last while req0 is pending -> exactly 4 stall cycles, then OWN0; gnt1 never asserts during the stall.
REQ-038 reset_bar pulsed low for 1 cycle with 2 beats in flight -> no rvalid afterward; busy=0 and all outputs 0 on the next edge.

Source files
------------

// File: rtl/image_read_arbiter.sv
// image_read_arbiter: two-requester round-robin burst arbiter for one image buffer read port
module image_read_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 12,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_bar,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              last0,
    input  logic              last1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [RD_LAT-1:0] vld_q, vld_d, tag_q, tag_d;
    logic              own0, own1, stall, rel, oreq, lst;
    logic [1:0]        idle_nxt, rel_nxt;

    // only the current owner's beat is forwarded; the address idles on addr0
    always_comb begin
        own0     = state_q == OWN0;
        own1     = state_q == OWN1;
        gnt0     = own0 & req0;
        gnt1     = own1 & req1;
        mem_re   = gnt0 | gnt1;
        mem_addr = !reset_bar ? '0 : gnt1 ? addr1 : addr0;
    end

    // ownership release on last beat or idle timeout, round-robin handover
    always_comb begin
        lst      = own1 ? last1 : last0;
        oreq     = own1 ? req0 : req1;
        stall    = (own0 | own1) & ~mem_re;
        rel      = (mem_re & lst) | (stall & (cnt_q == TO_LAST));
        cnt_d    = (mem_re | rel) ? '0 : stall ? cnt_q + 8'd1 : cnt_q;
        prio_d   = rel ? own0 : prio_q;
        idle_nxt = (req0 & req1) ? (prio_q ? OWN1 : OWN0) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
        rel_nxt  = !oreq ? IDLE : own0 ? OWN1 : OWN0;
        state_d  = (state_q == IDLE) ? idle_nxt : (own0 | own1) ? (rel ? rel_nxt : state_q) : IDLE;
    end

    // each granted beat travels down the read-latency pipe with its owner tag
    always_comb begin
        vld_d    = vld_q;
        tag_d    = tag_q;
        vld_d[0] = mem_re;
        tag_d[0] = gnt1;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    // state registers; reset drops every in-flight read
    always_ff @(posedge clock or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            tag_q   <= tag_d;
        end
    end

    assign rvalid0 = vld_q[RD_LAT-1] & ~tag_q[RD_LAT-1];
    assign rvalid1 = vld_q[RD_LAT-1] & tag_q[RD_LAT-1];
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;
    assign busy    = (state_q != IDLE) | (|vld_q);
endmodule

// File: tb/tb_image_read_arbiter.sv
// tb_image_read_arbiter: random and directed checks of two arbiter configurations against a beat-level model
module tb_image_read_arbiter;
    logic clock = 0, reset_bar = 0, req0 = 0, req1 = 0, last0 = 0, last1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0;
    logic [11:0] mrd = 0;
    logic [1:0] g0w, g1w, rv0w, rv1w, rew, bw;
    logic [15:0] maw[2];
    logic [11:0] rd0w[2], rd1w[2];
    int n_chk = 0, n_pass = 0, cyc = 0;
    typedef struct {int k; int due; bit tag;} beat_t;
    beat_t pq[$];
    int own[2] = '{-1, -1};
    int prio[2] = '{0, 0};
    int idle[2] = '{0, 0};

    always #5 clock = ~clock;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        image_read_arbiter #(.ADDR_W(16), .DATA_W(12), .RD_LAT(k ? 3 : 1), .TIMEOUT(k ? 4 : 255)) dut (
            .clock(clock), .reset_bar(reset_bar),
            .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
            .last0(last0), .last1(last1),
            .gnt0(g0w[k]), .gnt1(g1w[k]), .rvalid0(rv0w[k]), .rvalid1(rv1w[k]),
            .rdata0(rd0w[k]), .rdata1(rd1w[k]),
            .mem_re(rew[k]), .mem_addr(maw[k]), .mem_rdata(mrd), .busy(bw[k])
        );
    end

    function automatic int lat(int k);
        return k ? 3 : 1;
    endfunction

    function automatic int tmo(int k);
        return k ? 4 : 255;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    endtask

    task automatic set(input logic r0, input logic l0, input logic [15:0] a0,
                       input logic r1, input logic l1, input logic [15:0] a1);
        req0 = r0; last0 = l0; addr0 = a0;
        req1 = r1; last1 = l1; addr1 = a1;
    endtask

    // compare both DUTs with what the model says this cycle must look like
    task automatic eval();
        #3;
        for (int k = 0; k < 2; k++) begin
            logic e0, e1, v0, v1, b;
            logic [45:0] e, g;
            e0 = reset_bar && own[k] == 0 && req0;
            e1 = reset_bar && own[k] == 1 && req1;
            v0 = 0; v1 = 0;
            b = reset_bar && own[k] != -1;
            foreach (pq[i]) if (pq[i].k == k) begin
                if (pq[i].due >= cyc) b = 1;
                if (pq[i].due == cyc) begin
                    if (pq[i].tag) v1 = 1;
                    else v0 = 1;
                end
            end
            if (!reset_bar) begin v0 = 0; v1 = 0; b = 0; end
            e = {e0, e1, e0 | e1, v0, v1, b, !reset_bar ? 16'h0 : e1 ? addr1 : addr0, mrd, mrd};
            g = {g0w[k], g1w[k], rew[k], rv0w[k], rv1w[k], bw[k], maw[k], rd0w[k], rd1w[k]};
            chk($sformatf("dut%0d_outputs", k), 64'(g), 64'(e));
        end
    endtask

    task automatic model_next(input int k);
        bit r, l, o, rel;
        beat_t bt;
        if (own[k] == -1) begin
            if (req0 && req1) own[k] = prio[k];
            else if (req0) own[k] = 0;
            else if (req1) own[k] = 1;
        end else begin
            r = own[k] == 1 ? req1 : req0;
            l = own[k] == 1 ? last1 : last0;
            o = own[k] == 1 ? req0 : req1;
            rel = 0;
            if (r) begin
                idle[k] = 0;
                bt.k = k; bt.due = cyc + lat(k); bt.tag = own[k] == 1;
                pq.push_back(bt);
                rel = l;
            end else begin
                idle[k]++;
                if (idle[k] == tmo(k)) begin rel = 1; idle[k] = 0; end
            end
            if (rel) begin
                prio[k] = 1 - own[k];
                own[k] = o ? 1 - own[k] : -1;
            end
        end
    endtask

    // advance the model across the coming clock edge
    task automatic adv();
        beat_t nq[$];
        foreach (pq[i]) if (pq[i].due > cyc) nq.push_back(pq[i]);
        pq = nq;
        for (int k = 0; k < 2; k++) begin
            if (!reset_bar) begin own[k] = -1; prio[k] = 0; idle[k] = 0; end
            else model_next(k);
        end
        if (!reset_bar) pq.delete();
        @(posedge clock);
        #1;
        cyc++;
        mrd = 12'($urandom);
    endtask

    task automatic do_reset();
        reset_bar = 0;
        set(0, 0, 0, 0, 0, 0);
        eval();
        adv();
        reset_bar = 1;
    endtask

    initial begin
        @(posedge clock);
        #1;
        // 4-beat burst by requester 0, single-cycle latency
        do_reset();
        set(1, 0, 16'h10, 0, 0, 0); eval(); chk("s1_idle_nogrant", g0w[0], 0); adv();
        for (int i = 0; i < 4; i++) begin
            set(1, i == 3, 16'h10 + 16'(i), 0, 0, 0); eval();
            chk("s1_addr", maw[0], 16'h10 + 16'(i));
            chk("s1_re", rew[0], 1);
            if (i > 0) chk("s1_rv0", rv0w[0], 1);
            adv();
        end
        set(0, 0, 0, 0, 0, 0); eval(); chk("s1_last_rv0", {rv0w[0], rew[0]}, 2'b10); adv();
        eval(); chk("s1_back_idle", bw[0], 0); adv();
        // simultaneous requests and round-robin pointer
        do_reset();
        set(1, 0, 1, 1, 0, 2); eval(); chk("s2_idle", {g0w[0], g1w[0]}, 2'b00); adv();
        set(1, 1, 3, 1, 0, 4); eval(); chk("s2_own0", {g0w[0], g1w[0]}, 2'b10); adv();
        set(0, 0, 0, 1, 1, 5); eval(); chk("s2_own1_nogap", {g0w[0], g1w[0]}, 2'b01); adv();
        set(1, 0, 6, 1, 0, 7); eval(); chk("s2_idle_again", rew[0], 0); adv();
        set(1, 1, 8, 1, 1, 9); eval(); chk("s2_prio_back", {g0w[0], g1w[0]}, 2'b10); chk("s2_addr", maw[0], 8); adv();
        // back-to-back bursts through the 3-deep pipe
        do_reset();
        set(1, 0, 16'h20, 0, 0, 0); eval(); adv();
        set(1, 0, 16'h20, 0, 0, 0); eval(); chk("s3_gnt0", g0w[1], 1); adv();
        set(1, 1, 16'h21, 1, 0, 16'h30); eval(); adv();
        set(0, 0, 0, 1, 0, 16'h30); eval(); chk("s3_gnt1", {g0w[1], g1w[1]}, 2'b01); adv();
        set(0, 0, 0, 1, 1, 16'h31); eval(); chk("s3_rv_c4", {rv0w[1], rv1w[1]}, 2'b10); adv();
        for (int j = 5; j < 8; j++) begin
            set(0, 0, 0, 0, 0, 0); eval();
            chk("s3_rv_order", {rv0w[1], rv1w[1]}, j == 5 ? 2'b10 : 2'b01);
            adv();
        end
        // idle timeout of owner 1 with requester 0 waiting
        do_reset();
        set(0, 0, 0, 1, 0, 16'h40); eval(); adv();
        set(1, 0, 16'h50, 1, 0, 16'h40); eval(); chk("s4_gnt1", g1w[1], 1); adv();
        for (int s = 0; s < 4; s++) begin
            set(1, 0, 16'h50, 0, 0, 0); eval(); chk("s4_stall", {g0w[1], g1w[1]}, 2'b00); adv();
        end
        set(1, 1, 16'h50, 0, 0, 0); eval(); chk("s4_own0", g0w[1], 1); adv();
        // reset pulse with two beats in flight
        do_reset();
        set(1, 0, 16'h60, 0, 0, 0); eval(); adv();
        set(1, 0, 16'h60, 0, 0, 0); eval(); adv();
        set(1, 0, 16'h61, 0, 0, 0); eval(); adv();
        reset_bar = 0;
        set(0, 0, 0, 0, 0, 0); eval(); chk("s5_in_reset", {rew[1], bw[1], rv0w[1], rv1w[1]}, 4'b0); adv();
        reset_bar = 1;
        for (int j = 0; j < 2; j++) begin
            eval(); chk("s5_after", {g0w[1], g1w[1], rew[1], rv0w[1], rv1w[1], bw[1]}, 6'b0); adv();
        end
        // random traffic with occasional reset pulses
        for (int n = 0; n < 4000; n++) begin
            reset_bar = $urandom_range(199) != 0;
            set($urandom_range(3) != 0, $urandom_range(3) == 0, 16'($urandom),
                $urandom_range(3) != 0, $urandom_range(3) == 0, 16'($urandom));
            eval();
            adv();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
